serial_adder_seq: RTL and testbench



---
 rtl/serial_adder_seq_if.sv | 10 +
 rtl/serial_adder_seq.sv | 103 ++++++++++
 tb/tb_serial_adder_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_seq_if.sv
// serial_adder_seq_if: operand/result handshake bundle for serial_adder_seq
interface serial_adder_seq_if #(parameter int WIDTH = 8);
    logic             in_valid, in_ready, cin;
    logic [WIDTH-1:0] a, b, sum;
    logic             out_valid, out_ready, cout, overflow, err;
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, overflow, err);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, overflow, err);
endinterface

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: digit-serial adder iterating a DIGIT-bit slice LSB first.
// Define SERIAL_ADDER_DMR_EN to duplicate the slice and flag mismatches on err.
module serial_adder_seq_slice #(parameter int DIGIT = 1) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             cmsb
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + (DIGIT+1)'(ci);
    // carry into the top bit of the slice falls out of its sum bit
    assign cmsb = a[DIGIT-1] ^ b[DIGIT-1] ^ s[DIGIT-1];
endmodule

module serial_adder_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic clk,
    input logic rst_n,
    serial_adder_seq_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
        $error("serial_adder_seq: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;

    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CW-1:0]    cnt;
    logic             c_q, cout_q, ov_q, err_q, mismatch;
    logic [DIGIT-1:0] sum_pri;
    logic             co_pri, cm_pri;

    serial_adder_seq_slice #(.DIGIT(DIGIT)) u_pri (
        .a(a_q[DIGIT-1:0]), .b(b_q[DIGIT-1:0]), .ci(c_q),
        .s(sum_pri), .co(co_pri), .cmsb(cm_pri)
    );

`ifdef SERIAL_ADDER_DMR_EN
    logic [DIGIT-1:0] sum_chk;
    logic             co_chk, cm_chk;
    serial_adder_seq_slice #(.DIGIT(DIGIT)) u_chk (
        .a(a_q[DIGIT-1:0]), .b(b_q[DIGIT-1:0]), .ci(c_q),
        .s(sum_chk), .co(co_chk), .cmsb(cm_chk)
    );
    assign mismatch = {sum_pri, co_pri, cm_pri} != {sum_chk, co_chk, cm_chk};
`else
    assign mismatch = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (bus.in_valid  ? RUN  : IDLE) :
                  state == RUN  ? (cnt == '0     ? DONE : RUN)  :
                                  (bus.out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            ov_q   <= 1'b0;
            err_q  <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            a_q <= bus.a;
            b_q <= bus.b;
            c_q <= bus.cin;
            cnt <= CW'(N - 1);
        end else if (state == RUN) begin
            a_q   <= a_q >> DIGIT;
            b_q   <= b_q >> DIGIT;
            sum_q <= (sum_q >> DIGIT) | (WIDTH'(sum_pri) << (WIDTH - DIGIT));
            c_q   <= co_pri;
            cnt   <= cnt - CW'(1);
            err_q <= err_q | mismatch;
            if (cnt == '0) begin
                cout_q <= co_pri;
                ov_q   <= cm_pri ^ co_pri;
            end
        end
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ov_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: directed vectors for 8/1, 16/4 and 8/8 configurations.
module tb_serial_adder_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic err_exp = 1'b0;

    always #5 clk = ~clk;

    serial_adder_seq_if #(.WIDTH(8))  i8  ();
    serial_adder_seq_if #(.WIDTH(16)) i16 ();
    serial_adder_seq_if #(.WIDTH(8))  i88 ();

    serial_adder_seq #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    serial_adder_seq #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));
    serial_adder_seq #(.WIDTH(8),  .DIGIT(8)) dut88 (.clk(clk), .rst_n(rst_n), .bus(i88));

    typedef struct {
        logic [7:0] a, b;
        logic       ci;
        logic [7:0] s;
        logic       c, o;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_valid8(output int k);
        k = 0;
        while (!i8.out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic op8(input logic [7:0] a, b, input logic ci,
                       input logic [7:0] es, input logic ec, eo, input string nm);
        int k;
        k = 0;
        while (!i8.in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        i8.a = a; i8.b = b; i8.cin = ci; i8.in_valid = 1'b1;
        @(posedge clk); #1;
        i8.in_valid = 1'b0;
        wait_valid8(k);
        chk({nm, " latency"}, k, 8);
        chk({nm, " sum"}, i8.sum, es);
        chk({nm, " cout"}, i8.cout, ec);
        chk({nm, " overflow"}, i8.overflow, eo);
        chk({nm, " err"}, i8.err, err_exp);
        i8.out_ready = 1'b1;
        @(posedge clk); #1;
        i8.out_ready = 1'b0;
        chk({nm, " out_valid drop"}, i8.out_valid, 0);
        chk({nm, " in_ready rise"}, i8.in_ready, 1);
    endtask

    initial begin
        int k;
        tv[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
        tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[2] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        tv[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tv[4] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        tv[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        tv[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
        tv[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        {i8.in_valid, i8.a, i8.b, i8.cin, i8.out_ready} = '0;
        {i16.in_valid, i16.a, i16.b, i16.cin, i16.out_ready} = '0;
        {i88.in_valid, i88.a, i88.b, i88.cin, i88.out_ready} = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", i8.in_ready, 1);
        chk("reset out_valid", i8.out_valid, 0);
        chk("reset sum", i8.sum, 0);
        chk("reset cout", i8.cout, 0);
        chk("reset overflow", i8.overflow, 0);
        chk("reset err", i8.err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            op8(tv[i].a, tv[i].b, tv[i].ci, tv[i].s, tv[i].c, tv[i].o, $sformatf("vec%0d", i));

        // backpressure, plus in_valid held high through RUN with changed operands
        i8.a = 8'h3C; i8.b = 8'h5A; i8.cin = 1'b0; i8.in_valid = 1'b1;
        @(posedge clk); #1;
        i8.a = 8'h11; i8.b = 8'h22;
        chk("hold in_ready run", i8.in_ready, 0);
        wait_valid8(k);
        chk("hold latency", k, 8);
        i8.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d out_valid", i), i8.out_valid, 1);
            chk($sformatf("bp%0d in_ready", i), i8.in_ready, 0);
            chk($sformatf("bp%0d sum", i), i8.sum, 8'h96);
            chk($sformatf("bp%0d cout", i), i8.cout, 0);
            chk($sformatf("bp%0d overflow", i), i8.overflow, 1);
        end
        i8.out_ready = 1'b1;
        @(posedge clk); #1;
        i8.out_ready = 1'b0;
        chk("bp release in_ready", i8.in_ready, 1);
        chk("bp release out_valid", i8.out_valid, 0);

        // reset pulse while the counter sits at 3
        op8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, "pre_reset");
        i8.a = 8'h0F; i8.b = 8'h00; i8.cin = 1'b0; i8.in_valid = 1'b1;
        @(posedge clk); #1;
        i8.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun rst out_valid", i8.out_valid, 0);
        chk("midrun rst in_ready", i8.in_ready, 1);
        chk("midrun rst sum", i8.sum, 0);
        chk("midrun rst cout", i8.cout, 0);
        chk("midrun rst overflow", i8.overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        i8.a = 8'h3C; i8.b = 8'h5A; i8.in_valid = 1'b1;
        @(posedge clk); #1;
        i8.in_valid = 1'b0;
        wait_valid8(k);
        chk("post rst latency", k, 8);
        chk("post rst sum", i8.sum, 8'h96);
        i8.out_ready = 1'b1;
        @(posedge clk); #1;
        i8.out_ready = 1'b0;

        // WIDTH=16, DIGIT=4
        i16.a = 16'h7FFF; i16.b = 16'h0001; i16.cin = 1'b0; i16.in_valid = 1'b1;
        @(posedge clk); #1;
        i16.in_valid = 1'b0;
        k = 0;
        while (!i16.out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("w16 latency", k, 4);
        chk("w16 sum", i16.sum, 16'h8000);
        chk("w16 cout", i16.cout, 0);
        chk("w16 overflow", i16.overflow, 1);
        i16.in_valid = 1'b1; i16.out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            k = 0;
            while (i16.out_valid && k < 40) begin
                @(posedge clk); #1;
                k++;
            end
            while (!i16.out_valid && k < 40) begin
                @(posedge clk); #1;
                k++;
            end
            chk($sformatf("w16 spacing%0d", r), k, 6);
            chk($sformatf("w16 b2b sum%0d", r), i16.sum, 16'h8000);
        end
        i16.in_valid = 1'b0;
        @(posedge clk); #1;
        i16.out_ready = 1'b0;
        chk("w16 drain idle", i16.in_ready, 1);

        // DIGIT == WIDTH: single RUN cycle
        i88.a = 8'h3C; i88.b = 8'h5A; i88.cin = 1'b0; i88.in_valid = 1'b1;
        @(posedge clk); #1;
        i88.in_valid = 1'b0;
        k = 0;
        while (!i88.out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("w8d8 latency", k, 1);
        chk("w8d8 sum", i88.sum, 8'h96);
        chk("w8d8 cout", i88.cout, 0);
        chk("w8d8 overflow", i88.overflow, 1);
        i88.out_ready = 1'b1;
        @(posedge clk); #1;
        i88.out_ready = 1'b0;

`ifdef SERIAL_ADDER_DMR_EN
        op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "dmr clean");
        i8.a = 8'h00; i8.b = 8'h00; i8.cin = 1'b0; i8.in_valid = 1'b1;
        @(posedge clk); #1;
        i8.in_valid = 1'b0;
        force dut8.sum_chk = 1'b1;
        @(posedge clk); #1;
        release dut8.sum_chk;
        wait_valid8(k);
        chk("dmr fault latency", k, 7);
        chk("dmr fault sum", i8.sum, 8'h00);
        chk("dmr fault err", i8.err, 1);
        i8.out_ready = 1'b1;
        @(posedge clk); #1;
        i8.out_ready = 1'b0;
        err_exp = 1'b1;
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "dmr sticky");
        rst_n = 1'b0;
        #1;
        chk("dmr reset err", i8.err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
`endif
        chk("final err", i8.err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
